lab4_rgb_pwm: RTL and testbench

- Downstream stage of the 2-bit comparator; consumes its red/green/blue level outputs and drives the board RGB LED pins.
- Synchronises each level and PWM-dims each channel to a fixed duty.
- On any change of the comparison result, drives all lit channels at full brightness for a fixed flash window, then returns to dimmed output.

---
 rtl/lab4_pkg.sv | 16 +
 rtl/sync2.sv | 27 ++
 rtl/lab4_rgb_pwm.sv | 101 ++++++++++
 tb/tb_lab4_rgb_pwm.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/lab4_pkg.sv
// Shared types and default constants for the RGB LED PWM/flash stage.
`default_nettype none

package lab4_pkg;

  typedef enum logic {
    DIM   = 1'b0,
    FLASH = 1'b1
  } rgb_state_t;

  localparam int PWM_BITS_DEF     = 8;
  localparam int FLASH_CYCLES_DEF = 1000000;

endpackage

`default_nettype wire

// File: rtl/sync2.sv
// Parameterised-width two-flop synchroniser with synchronous active-high reset.
`default_nettype none

module sync2 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

`default_nettype wire

// File: rtl/lab4_rgb_pwm.sv
// RGB LED driver: synchronises comparator levels, PWM-dims each channel and
// flashes lit channels at full brightness for a fixed window after any change.
`default_nettype none

module lab4_rgb_pwm
  import lab4_pkg::*;
#(
  parameter int PWM_BITS     = PWM_BITS_DEF,
  parameter int DUTY_R       = 32,
  parameter int DUTY_G       = 32,
  parameter int DUTY_B       = 32,
  parameter int FLASH_CYCLES = FLASH_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic red_in,
  input  logic green_in,
  input  logic blue_in,
  output logic led_r,
  output logic led_g,
  output logic led_b,
  output logic flash_active
);

  localparam int FW = (FLASH_CYCLES > 1) ? $clog2(FLASH_CYCLES) : 1;
  localparam logic [FW-1:0] FLASH_RELOAD = FW'(FLASH_CYCLES - 1);

  // Duties are one bit wider than the counter so the full-period value fits.
  localparam logic [PWM_BITS:0] DUTY_R_W = (PWM_BITS + 1)'(DUTY_R);
  localparam logic [PWM_BITS:0] DUTY_G_W = (PWM_BITS + 1)'(DUTY_G);
  localparam logic [PWM_BITS:0] DUTY_B_W = (PWM_BITS + 1)'(DUTY_B);

  logic [2:0]          s;
  logic [2:0]          prev;
  logic [PWM_BITS-1:0] cnt;
  logic [FW-1:0]       fcnt;
  rgb_state_t          state;
  logic                change;
  logic                flash_next;
  logic [2:0]          pwm;

  sync2 #(
    .WIDTH (3)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   ({red_in, green_in, blue_in}),
    .q   (s)
  );

  assign change     = (s != prev);
  assign flash_next = change | ((state == FLASH) && (fcnt != '0));

  assign pwm = {({1'b0, cnt} < DUTY_R_W),
                ({1'b0, cnt} < DUTY_G_W),
                ({1'b0, cnt} < DUTY_B_W)};

  always_ff @(posedge clk) begin
    if (rst) begin
      prev         <= '0;
      cnt          <= '0;
      fcnt         <= '0;
      state        <= DIM;
      led_r        <= 1'b0;
      led_g        <= 1'b0;
      led_b        <= 1'b0;
      flash_active <= 1'b0;
    end else begin
      prev <= s;
      cnt  <= cnt + 1'b1;

      case (state)
        DIM: begin
          if (change) begin
            state <= FLASH;
            fcnt  <= FLASH_RELOAD;
          end
        end
        FLASH: begin
          // A change in the final cycle retriggers instead of exiting.
          if (change) begin
            fcnt <= FLASH_RELOAD;
          end else if (fcnt != '0) begin
            fcnt <= fcnt - 1'b1;
          end else begin
            state <= DIM;
          end
        end
        default: state <= DIM;
      endcase

      led_r        <= s[2] & (flash_next | pwm[2]);
      led_g        <= s[1] & (flash_next | pwm[1]);
      led_b        <= s[0] & (flash_next | pwm[0]);
      flash_active <= (state == FLASH);
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_lab4_rgb_pwm.sv
// Scoreboard bench for lab4_rgb_pwm with a small PWM period and short flash.
`default_nettype none

module tb_lab4_rgb_pwm;

  localparam int PB    = 4;
  localparam int DR    = 4;
  localparam int DG    = 8;
  localparam int DB    = 16;
  localparam int FLASH = 5;

  typedef struct packed {
    logic [2:0] led;
    logic       fa;
    logic       r2;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic red_in = 1'b0, green_in = 1'b0, blue_in = 1'b0;
  logic led_r, led_g, led_b, flash_active;
  logic led_r2, led_g2, led_b2, flash_active2;

  int total = 0;
  int bad   = 0;

  exp_t sbq[$];

  // Reference model state
  logic [2:0] m_s1 = '0, m_s2 = '0, m_prev = '0;
  int         m_cnt = 0;
  int         m_left = 0;
  logic       m_fprev = 1'b0;

  always #5 clk = ~clk;

  lab4_rgb_pwm #(
    .PWM_BITS(PB), .DUTY_R(DR), .DUTY_G(DG), .DUTY_B(DB), .FLASH_CYCLES(FLASH)
  ) dut (
    .clk(clk), .rst(rst), .red_in(red_in), .green_in(green_in), .blue_in(blue_in),
    .led_r(led_r), .led_g(led_g), .led_b(led_b), .flash_active(flash_active)
  );

  lab4_rgb_pwm #(
    .PWM_BITS(PB), .DUTY_R(0), .DUTY_G(DG), .DUTY_B(DB), .FLASH_CYCLES(FLASH)
  ) dut0 (
    .clk(clk), .rst(rst), .red_in(red_in), .green_in(green_in), .blue_in(blue_in),
    .led_r(led_r2), .led_g(led_g2), .led_b(led_b2), .flash_active(flash_active2)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d want=%0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Behavioural model: a change lights every active channel for FLASH edges,
  // flash_active trails the full-brightness window by one edge.
  always @(posedge clk) begin
    exp_t e;
    logic fl;
    logic [2:0] pw;
    if (rst) begin
      m_s1 = '0; m_s2 = '0; m_prev = '0; m_cnt = 0; m_left = 0; m_fprev = 1'b0;
      e = '0;
    end else begin
      if (m_s2 != m_prev) begin
        fl = 1'b1; m_left = FLASH - 1;
      end else if (m_left > 0) begin
        fl = 1'b1; m_left--;
      end else begin
        fl = 1'b0;
      end
      pw = {m_cnt < DR, m_cnt < DG, m_cnt < DB};
      e.led = m_s2 & (fl ? 3'b111 : pw);
      e.r2  = m_s2[2] & fl;
      e.fa  = m_fprev;
      m_fprev = fl;
      m_prev = m_s2;
      m_s2   = m_s1;
      m_s1   = {red_in, green_in, blue_in};
      m_cnt  = (m_cnt + 1) % (1 << PB);
    end
    sbq.push_back(e);
  end

  always @(negedge clk) begin
    exp_t e;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      chk("led_rgb", int'({led_r, led_g, led_b}), int'(e.led));
      chk("flash_active", int'(flash_active), int'(e.fa));
      chk("led_r_duty0", int'(led_r2), int'(e.r2));
    end
  end

  task automatic drive(input logic [2:0] v);
    {red_in, green_in, blue_in} = v;
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic count_window(input int n, output int cr, output int cg,
                              output int cb, output int cr2, output int cfa);
    cr = 0; cg = 0; cb = 0; cr2 = 0; cfa = 0;
    repeat (n) begin
      @(negedge clk);
      cr += int'(led_r); cg += int'(led_g); cb += int'(led_b);
      cr2 += int'(led_r2); cfa += int'(flash_active);
    end
  endtask

  initial begin
    int cr, cg, cb, cr2, cfa;

    // Reset held three cycles with all inputs high
    drive(3'b111);
    rst = 1'b1;
    step(3);
    chk("reset_leds", int'({led_r, led_g, led_b}), 0);
    chk("reset_fa", int'(flash_active), 0);
    rst = 1'b0;
    step(1);
    chk("post_rst_e1_led", int'({led_r, led_g, led_b}), 0);
    step(1);
    chk("post_rst_e2_led", int'({led_r, led_g, led_b}), 0);
    step(1);
    chk("post_rst_e3_led", int'({led_r, led_g, led_b}), 7);
    chk("post_rst_e3_fa", int'(flash_active), 0);
    count_window(20, cr, cg, cb, cr2, cfa);
    chk("reset_flash_fa_len", cfa, FLASH);

    // Steady all-on: per-period duty counts
    count_window(16, cr, cg, cb, cr2, cfa);
    chk("duty_r_all", cr, DR);
    chk("duty_g_all", cg, DG);
    chk("duty_b_all", cb, DB);
    chk("duty_r_zero", cr2, 0);

    // Steady red only
    drive(3'b100);
    step(30);
    count_window(16, cr, cg, cb, cr2, cfa);
    chk("red_only_r", cr, DR);
    chk("red_only_g", cg, 0);
    chk("red_only_b", cb, 0);
    chk("red_only_fa", cfa, 0);

    // Flash from DIM near cnt=10 by raising green
    for (int i = 0; i < 40 && m_cnt != 10; i++) @(negedge clk);
    drive(3'b110);
    count_window(30, cr, cg, cb, cr2, cfa);
    chk("green_flash_fa_len", cfa, FLASH);

    // Retrigger three cycles into the flash
    step(10);
    drive(3'b111);
    step(3);
    drive(3'b110);
    count_window(30, cr, cg, cb, cr2, cfa);
    chk("retrigger_fa_len", cfa, FLASH + 3);

    // Reset mid-flash, then release with inputs unchanged
    step(10);
    drive(3'b011);
    step(2 + FLASH - 2);
    rst = 1'b1;
    step(1);
    chk("midflash_rst_leds", int'({led_r, led_g, led_b}), 0);
    chk("midflash_rst_fa", int'(flash_active), 0);
    rst = 1'b0;
    count_window(30, cr, cg, cb, cr2, cfa);
    chk("post_midrst_fa_len", cfa, FLASH);

    // Glitch: one-cycle pulse on red gives one retriggered flash
    drive(3'b111);
    step(1);
    drive(3'b011);
    count_window(30, cr, cg, cb, cr2, cfa);
    chk("glitch_fa_len", cfa, FLASH + 1);

    step(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
